// File: rtl/mux_rr_sel_gen.sv
// -----------------------------------------------------------------------------
// mux_rr_sel_gen
//
// Round-robin select generator for the mux_16x1 datapath stage. Arbitrates
// among DEPTH channel requests and holds the winning select for a burst of
// (burst_len + 1) beats accepted over a valid/ready handshake. When a burst
// ends and another request is pending, the next grant is loaded on the same
// edge, so there is no bubble on s_valid.
//
// Optional feature macro: MUX_SEL_PRIO0_EN
//   When defined, channel 0 wins every arbitration it requests, and finishing
//   a channel-0 burst leaves the rotation pointer untouched.
//
// Parameters
//   DEPTH     number of mux channels (2..16)
//   SEL_W     select width, must equal $clog2(DEPTH)
//   BURST_W   width of the burst-length input
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   arbitration enable
//   req        in   per-channel request bits [DEPTH-1:0]
//   burst_len  in   beats per grant minus one, sampled at grant time
//   ready      in   consumer accepts the current beat
//   s          out  mux select (index of granted channel)
//   s_valid    out  s is valid and a beat is offered
//   grant      out  one-hot grant, zero when idle
//   busy       out  high while a burst is in progress
// -----------------------------------------------------------------------------
module mux_rr_sel_gen #(
  parameter int DEPTH   = 16,
  parameter int SEL_W   = 4,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DEPTH-1:0]   req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               ready,
  output logic [SEL_W-1:0]   s,
  output logic               s_valid,
  output logic [DEPTH-1:0]   grant,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic [BURST_W-1:0] r_cnt;
  logic [BURST_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0]   r_s;
  logic [SEL_W-1:0]   w_s_nxt;
  logic [DEPTH-1:0]   r_grant;
  logic [DEPTH-1:0]   w_grant_nxt;

  logic               w_accept;
  logic               w_arb_req;
  logic [SEL_W-1:0]   w_rot_ptr;
  logic [SEL_W-1:0]   w_arb_base;
  logic [SEL_W-1:0]   w_pick;
  logic [DEPTH-1:0]   w_pick_onehot;

  // First set request bit scanning base, base+1, ..., DEPTH-1, 0, ..., base-1.
  // base is always < DEPTH, so the winner can never be an out-of-range index.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [DEPTH-1:0] r,
                                               input logic [SEL_W-1:0] base);
    logic [SEL_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(base) + i;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (!found && r[idx]) begin
        pick  = SEL_W'(idx);
        found = 1'b1;
      end
    end
`ifdef MUX_SEL_PRIO0_EN
    if (r[0]) pick = '0;
`endif
    return pick;
  endfunction

  assign w_accept  = (r_state == ST_HOLD) && ready;
  assign w_arb_req = en && (|req);

  // Pointer after the current burst finishes: one past the granted channel,
  // wrapping at DEPTH-1 rather than at 2^SEL_W-1.
`ifdef MUX_SEL_PRIO0_EN
  assign w_rot_ptr = (r_s == '0) ? r_ptr :
                     (r_s == SEL_W'(DEPTH - 1)) ? '0 : r_s + SEL_W'(1);
`else
  assign w_rot_ptr = (r_s == SEL_W'(DEPTH - 1)) ? '0 : r_s + SEL_W'(1);
`endif

  // In HOLD the only arbitration edge is the last accepted beat, which must
  // search from the already-advanced pointer.
  assign w_arb_base    = (r_state == ST_HOLD) ? w_rot_ptr : r_ptr;
  assign w_pick        = rr_pick(req, w_arb_base);
  assign w_pick_onehot = DEPTH'(1) << w_pick;

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_grant_nxt = r_grant;

    unique case (r_state)
      ST_IDLE: begin
        if (w_arb_req) begin
          w_state_nxt = ST_HOLD;
          w_s_nxt     = w_pick;
          w_grant_nxt = w_pick_onehot;
          w_cnt_nxt   = burst_len;
        end
      end
      ST_HOLD: begin
        if (w_accept) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - BURST_W'(1);
          end else begin
            w_ptr_nxt = w_rot_ptr;
            if (w_arb_req) begin
              w_s_nxt     = w_pick;
              w_grant_nxt = w_pick_onehot;
              w_cnt_nxt   = burst_len;
            end else begin
              // s deliberately keeps its last value in IDLE.
              w_state_nxt = ST_IDLE;
              w_grant_nxt = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  assign s       = r_s;
  assign grant   = r_grant;
  assign s_valid = (r_state == ST_HOLD);
  assign busy    = (r_state == ST_HOLD);

endmodule

// File: tb/tb_mux_rr_sel_gen.sv
module tb_mux_rr_sel_gen;

  logic        clk;
  logic        rst;

  // DUT A: default 16-channel configuration
  logic        en;
  logic [15:0] req;
  logic [3:0]  burst_len;
  logic        ready;
  logic [3:0]  s;
  logic        s_valid;
  logic [15:0] grant;
  logic        busy;

  // DUT B: 10-channel configuration for the non-power-of-2 wrap
  logic        en2;
  logic [9:0]  req2;
  logic [3:0]  burst_len2;
  logic        ready2;
  logic [3:0]  s2;
  logic        s_valid2;
  logic [9:0]  grant2;
  logic        busy2;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_q[$];
  int exp_q2[$];

  mux_rr_sel_gen #(.DEPTH(16), .SEL_W(4), .BURST_W(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .burst_len(burst_len),
    .ready(ready), .s(s), .s_valid(s_valid), .grant(grant), .busy(busy)
  );

  mux_rr_sel_gen #(.DEPTH(10), .SEL_W(4), .BURST_W(4)) u_dut10 (
    .clk(clk), .rst(rst), .en(en2), .req(req2), .burst_len(burst_len2),
    .ready(ready2), .s(s2), .s_valid(s_valid2), .grant(grant2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Monitors: one beat is accepted at the next rising edge whenever
  // s_valid && ready is seen here (inputs change only just after an edge).
  always @(negedge clk) begin
    if (!rst && s_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_a: unexpected beat s=%0d", s);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("beat_a_s", 32'(s), 32'(e));
        check("beat_a_grant", 32'(grant), 32'(16'(1) << e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_valid2 && ready2) begin
      if (exp_q2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL beat_b: unexpected beat s=%0d", s2);
      end else begin
        int e;
        e = exp_q2.pop_front();
        check("beat_b_s", 32'(s2), 32'(e));
        check("beat_b_grant", 32'(grant2), 32'(10'(1) << e));
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b0; req = '0; burst_len = '0; ready = 1'b0;
    en2 = 1'b0; req2 = '0; burst_len2 = '0; ready2 = 1'b0;
    #12;
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_s", 32'(s), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 1. Reset mid-burst
    en = 1'b1; req = 16'h0008; burst_len = 4'd2; ready = 1'b0;
    tick();
    check("t1_hold_s", 32'(s), 32'd3);
    check("t1_hold_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("t1_async_s", 32'(s), 32'd0);
    check("t1_async_valid", 32'(s_valid), 32'd0);
    check("t1_async_grant", 32'(grant), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b0;
    req = 16'h0010; burst_len = 4'd0;
    tick();
    check("t1_regrant_s", 32'(s), 32'd4);
    check("t1_regrant_valid", 32'(s_valid), 32'd1);
    req = '0; ready = 1'b1;
    exp_q.push_back(4);
    tick();
    ready = 1'b0;
    check("t1_idle_valid", 32'(s_valid), 32'd0);
    check("t1_idle_grant", 32'(grant), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_s_kept", 32'(s), 32'd4);

    // 2. Round-robin rotation, no bubbles
    do_reset();
    req = 16'h8421; burst_len = 4'd0; ready = 1'b1;
    foreach (exp_q[i]) ;
    exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(10);
    exp_q.push_back(15); exp_q.push_back(0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t2_no_bubble", 32'(s_valid), 32'd1);
      tick();
    end
    req = '0;
    check("t2_last_valid", 32'(s_valid), 32'd1);
    tick();
    ready = 1'b0;
    check("t2_idle", 32'(s_valid), 32'd0);

    // 3. Burst hold with backpressure (ptr is 1 here)
    req = 16'h0008; burst_len = 4'd3;
    for (int k = 0; k < 4; k++) exp_q.push_back(3);
    tick();
    req = '0;
    for (int j = 0; j < 7; j++) begin
      ready = (j % 2 == 0);
      check("t3_hold_s", 32'(s), 32'd3);
      check("t3_hold_valid", 32'(s_valid), 32'd1);
      check("t3_hold_grant", 32'(grant), 32'h0008);
      tick();
    end
    ready = 1'b0;
    check("t3_idle_valid", 32'(s_valid), 32'd0);
    check("t3_idle_busy", 32'(busy), 32'd0);

    // 5. en and req drop mid-burst (ptr is 4, search wraps to 2)
    req = 16'h0004; burst_len = 4'd2; ready = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(2);
    tick();
    check("t5_grant_s", 32'(s), 32'd2);
    tick();
    en = 1'b0; req = '0; burst_len = 4'd15;
    check("t5_beat2_s", 32'(s), 32'd2);
    tick();
    check("t5_beat3_s", 32'(s), 32'd2);
    check("t5_beat3_valid", 32'(s_valid), 32'd1);
    tick();
    ready = 1'b0;
    check("t5_idle_valid", 32'(s_valid), 32'd0);
    check("t5_idle_grant", 32'(grant), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);

    // Max burst length: 16 beats (ptr is 3, search wraps to 1)
    en = 1'b1; req = 16'h0002; burst_len = 4'd15; ready = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(1);
    tick();
    req = '0; burst_len = 4'd0;
    for (int k = 0; k < 16; k++) begin
      check("tmax_busy", 32'(busy), 32'd1);
      tick();
    end
    ready = 1'b0;
    check("tmax_idle", 32'(busy), 32'd0);

    // 4. Wrap at DEPTH-1 on a 10-channel instance
    do_reset();
    en2 = 1'b1; req2 = 10'h100; burst_len2 = 4'd0; ready2 = 1'b1;
    exp_q2.push_back(8); exp_q2.push_back(9); exp_q2.push_back(0);
    tick();
    req2 = 10'h201;
    tick();
    check("t4_s9", 32'(s2), 32'd9);
    tick();
    check("t4_s0", 32'(s2), 32'd0);
    req2 = '0;
    tick();
    ready2 = 1'b0;
    check("t4_idle", 32'(s_valid2), 32'd0);

    // 6. Channel-0 priority (or plain rotation when the feature is off)
    do_reset();
    en = 1'b1; req = 16'h0007; burst_len = 4'd0; ready = 1'b1;
`ifdef MUX_SEL_PRIO0_EN
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
`endif
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(2);
    tick();
    for (int k = 0; k < 3; k++) tick();
    req = 16'h0006;
    for (int k = 0; k < 4; k++) tick();
    req = '0;
    tick();
    ready = 1'b0;
    check("t6_idle", 32'(s_valid), 32'd0);

    @(negedge clk);
    check("drain_a", 32'(exp_q.size()), 32'd0);
    check("drain_b", 32'(exp_q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
